ysyx_22041752_mem_arb: RTL

- Two-requester arbiter that shares one memory port between instruction fetch (IF, read-only) and the execute-stage load/store path (LS: data_en/data_wen/data_addr/data_wdata).
- Sequences one outstanding transaction at a time, routes each response back to its owner, and discards IF responses made stale by a pipeline flush.
- LS has priority over IF, with a streak counter that prevents IF starvation.
- Sits between IFU/EXU and the SRAM/AXI bridge.

---
 rtl/ysyx_22041752_mem_arb_pkg.sv | 17 +
 rtl/ysyx_22041752_mem_arb_if.sv | 56 +++++
 rtl/ysyx_22041752_mem_arb_pick.sv | 45 ++++
 rtl/ysyx_22041752_mem_arb.sv | 118 +++++++++++
 4 files changed

// File: rtl/ysyx_22041752_mem_arb_pkg.sv
// Shared constants for the IF/LS memory-port arbiter: default widths,
// FSM state encodings and transaction owner codes.
package ysyx_22041752_mem_arb_pkg;

    localparam int ARB_ADDR_WD      = 32;
    localparam int ARB_DATA_WD      = 64;
    localparam int ARB_WEN_WD       = ARB_DATA_WD / 8;
    localparam int ARB_STARVE_LIMIT = 4;

    localparam logic [1:0] ARB_IDLE = 2'd0;
    localparam logic [1:0] ARB_REQ  = 2'd1;
    localparam logic [1:0] ARB_WAIT = 2'd2;

    localparam logic ARB_OWN_IF = 1'b0;
    localparam logic ARB_OWN_LS = 1'b1;

endpackage

// File: rtl/ysyx_22041752_mem_arb_if.sv
// Bundle of requester, downstream memory and status signals around the arbiter.
// master = arbiter side, slave = IFU/EXU/bridge side.
interface ysyx_22041752_mem_arb_if #(
    parameter int ADDR_WD = ysyx_22041752_mem_arb_pkg::ARB_ADDR_WD,
    parameter int DATA_WD = ysyx_22041752_mem_arb_pkg::ARB_DATA_WD,
    parameter int WEN_WD  = ysyx_22041752_mem_arb_pkg::ARB_WEN_WD
);
    logic               flush;

    logic               if_req_valid;
    logic               if_req_ready;
    logic [ADDR_WD-1:0] if_addr;
    logic               if_resp_valid;
    logic [DATA_WD-1:0] if_rdata;

    logic               ls_req_valid;
    logic               ls_req_ready;
    logic [WEN_WD-1:0]  ls_wen;
    logic [ADDR_WD-1:0] ls_addr;
    logic [DATA_WD-1:0] ls_wdata;
    logic               ls_resp_valid;
    logic [DATA_WD-1:0] ls_rdata;

    logic               mem_req_valid;
    logic               mem_req_ready;
    logic [ADDR_WD-1:0] mem_addr;
    logic [WEN_WD-1:0]  mem_wen;
    logic [DATA_WD-1:0] mem_wdata;
    logic               mem_resp_valid;
    logic [DATA_WD-1:0] mem_rdata;

    logic               busy;

    modport master (
        input  flush,
        input  if_req_valid, if_addr,
        output if_req_ready, if_resp_valid, if_rdata,
        input  ls_req_valid, ls_wen, ls_addr, ls_wdata,
        output ls_req_ready, ls_resp_valid, ls_rdata,
        output mem_req_valid, mem_addr, mem_wen, mem_wdata,
        input  mem_req_ready, mem_resp_valid, mem_rdata,
        output busy
    );

    modport slave (
        output flush,
        output if_req_valid, if_addr,
        input  if_req_ready, if_resp_valid, if_rdata,
        output ls_req_valid, ls_wen, ls_addr, ls_wdata,
        input  ls_req_ready, ls_resp_valid, ls_rdata,
        input  mem_req_valid, mem_addr, mem_wen, mem_wdata,
        output mem_req_ready, mem_resp_valid, mem_rdata,
        input  busy
    );

endinterface

// File: rtl/ysyx_22041752_mem_arb_pick.sv
// Winner selection between IF and LS in IDLE, with the LS streak counter
// that forces IF through after STARVE_LIMIT back-to-back LS grants.
module ysyx_22041752_mem_arb_pick
    import ysyx_22041752_mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = ARB_STARVE_LIMIT
) (
    input  logic clk,
    input  logic reset,
    input  logic i_idle,
    input  logic i_flush,
    input  logic i_if_valid,
    input  logic i_ls_valid,
    output logic o_grant_if,
    output logic o_grant_ls
);

    localparam int STREAK_WD = $clog2(STARVE_LIMIT + 1);
    localparam logic [STREAK_WD-1:0] STREAK_MAX = STREAK_WD'(STARVE_LIMIT);

    logic [STREAK_WD-1:0] r_streak;
    logic                 w_if_elig;
    logic                 w_force_if;

    // A flushed fetch is not a real request, so it can neither win nor force.
    assign w_if_elig  = i_if_valid && !i_flush;
    assign w_force_if = w_if_elig && (r_streak == STREAK_MAX);
    assign o_grant_ls = i_idle && i_ls_valid && !w_force_if;
    assign o_grant_if = i_idle && w_if_elig && !o_grant_ls;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_streak <= '0;
        end else if (o_grant_if) begin
            r_streak <= '0;
        end else if (o_grant_ls) begin
            if (!i_if_valid)
                r_streak <= '0;
            else if (r_streak != STREAK_MAX)
                r_streak <= r_streak + 1'b1;
        end
    end

endmodule

// File: rtl/ysyx_22041752_mem_arb.sv
// Shares one memory port between instruction fetch and load/store: one
// outstanding transaction, responses routed to the owner, stale IF data dropped.
module ysyx_22041752_mem_arb
    import ysyx_22041752_mem_arb_pkg::*;
#(
    parameter int ADDR_WD      = ARB_ADDR_WD,
    parameter int DATA_WD      = ARB_DATA_WD,
    parameter int WEN_WD       = ARB_WEN_WD,
    parameter int STARVE_LIMIT = ARB_STARVE_LIMIT
) (
    input  logic                     clk,
    input  logic                     reset,
    ysyx_22041752_mem_arb_if.master  bus
);

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic               r_owner;
    logic               r_drop;
    logic [ADDR_WD-1:0] r_addr;
    logic [WEN_WD-1:0]  r_wen;
    logic [DATA_WD-1:0] r_wdata;
    logic               r_if_resp;
    logic               r_ls_resp;
    logic [DATA_WD-1:0] r_rdata;

    logic w_idle;
    logic w_grant_if;
    logic w_grant_ls;
    logic w_done;

    assign w_idle = (r_state == ARB_IDLE);
    assign w_done = (r_state == ARB_WAIT) && bus.mem_resp_valid;

    ysyx_22041752_mem_arb_pick #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_pick (
        .clk        (clk),
        .reset      (reset),
        .i_idle     (w_idle),
        .i_flush    (bus.flush),
        .i_if_valid (bus.if_req_valid),
        .i_ls_valid (bus.ls_req_valid),
        .o_grant_if (w_grant_if),
        .o_grant_ls (w_grant_ls)
    );

    always_comb begin
        // NOTE: default assignment first, so no path through the case leaves it unassigned (no latch).
        w_state_nxt = r_state;
        case (r_state)
            ARB_IDLE: if (w_grant_if || w_grant_ls) w_state_nxt = ARB_REQ;
            ARB_REQ:  if (bus.mem_req_ready)        w_state_nxt = ARB_WAIT;
            ARB_WAIT: if (bus.mem_resp_valid)       w_state_nxt = ARB_IDLE;
            default:                                w_state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ARB_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Payload is captured once at grant and held untouched through REQ and WAIT.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_owner <= ARB_OWN_IF;
            r_addr  <= '0;
            r_wen   <= '0;
            r_wdata <= '0;
        end else if (w_grant_ls) begin
            r_owner <= ARB_OWN_LS;
            r_addr  <= bus.ls_addr;
            r_wen   <= bus.ls_wen;
            r_wdata <= bus.ls_wdata;
        end else if (w_grant_if) begin
            r_owner <= ARB_OWN_IF;
            r_addr  <= bus.if_addr;
            r_wen   <= '0;
            r_wdata <= '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_drop <= 1'b0;
        else if (w_done)
            r_drop <= 1'b0;
        else if (bus.flush && !w_idle && (r_owner == ARB_OWN_IF))
            r_drop <= 1'b1;
    end

    // A flush arriving with the response itself also kills the IF pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_if_resp <= 1'b0;
            r_ls_resp <= 1'b0;
            r_rdata   <= '0;
        end else begin
            r_if_resp <= w_done && (r_owner == ARB_OWN_IF) && !r_drop && !bus.flush;
            r_ls_resp <= w_done && (r_owner == ARB_OWN_LS);
            if (w_done) r_rdata <= bus.mem_rdata;
        end
    end

    assign bus.if_req_ready  = w_grant_if;
    assign bus.ls_req_ready  = w_grant_ls;
    assign bus.if_resp_valid = r_if_resp;
    assign bus.ls_resp_valid = r_ls_resp;
    assign bus.if_rdata      = r_rdata;
    assign bus.ls_rdata      = r_rdata;
    assign bus.mem_req_valid = (r_state == ARB_REQ);
    assign bus.mem_addr      = r_addr;
    assign bus.mem_wen       = r_wen;
    assign bus.mem_wdata     = r_wdata;
    assign bus.busy          = !w_idle;

endmodule
